// File: rtl/clk_div_sched.sv
// clk_div_sched: programmable divided-clock scheduler.
//
// Derives clk_out from clk with a run-time reloadable half-period. A new
// half-period is swapped in only on a clk_out toggle edge, so no phase is ever
// truncated. Supports free-run, burst (N full periods) and a graceful stop that
// always completes a started high phase.
//
// Ports
//   clk, reset          system clock, async active-high reset
//   enable              run request (level)
//   burst_mode          1 = burst, 0 = free-run (sampled at start)
//   burst_len [BW]      full clk_out periods per burst (sampled at start)
//   half_in [CW], load  load strobe captures half_in as pending half-period
//   load_ack            pulse on the cycle cur_half takes the pending value
//   cur_half [CW]       half-period in effect
//   clk_out             divided clock (registered)
//   tick                pulse aligned with the first high cycle of clk_out
//   busy                running or finishing a stop
//   done                pulse when a burst completes
module clk_div_sched #(
  parameter int CW           = 8,
  parameter int DEFAULT_HALF = 6,
  parameter int BW           = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          burst_mode,
  input  logic [BW-1:0] burst_len,
  input  logic [CW-1:0] half_in,
  input  logic          load,
  output logic          load_ack,
  output logic [CW-1:0] cur_half,
  output logic          clk_out,
  output logic          tick,
  output logic          busy,
  output logic          done
);

  // A zero half-period would never toggle; clamp to 1 everywhere.
  localparam logic [CW-1:0] RST_HALF = (DEFAULT_HALF == 0) ? CW'(1) : CW'(DEFAULT_HALF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOP
  } state_e;

  typedef struct packed {
    logic          mode;
    logic [BW-1:0] len;
  } burst_cfg_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] half_q, half_d;
  logic [CW-1:0] pval_q, pval_d;
  logic          pend_q, pend_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  burst_cfg_t    cfg_q, cfg_d;
  logic          armed_q, armed_d;
  logic          clk_q, clk_d;
  logic          tick_q, tick_d;
  logic          ack_q, ack_d;
  logic          done_q, done_d;

  logic [CW-1:0] half_in_c;
  logic          toggle;
  logic          apply;

  assign half_in_c = (half_in == '0) ? CW'(1) : half_in;
  assign toggle    = (cnt_q == half_q - CW'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    pval_d  = pval_q;
    pend_d  = pend_q;
    bcnt_d  = bcnt_q;
    cfg_d   = cfg_q;
    armed_d = armed_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    apply   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        // A load in flight is applied before a run may start, so the run
        // always begins with the newest half-period.
        if (pend_q) begin
          apply = 1'b1;
        end else if (enable && armed_q && !load) begin
          state_d    = S_RUN;
          cfg_d.mode = burst_mode;
          cfg_d.len  = burst_len;
          bcnt_d     = '0;
        end
        if (!enable) armed_d = 1'b1;
      end

      S_RUN: begin
        if (!enable && !clk_q) begin
          // Low phase: stop right away, never emit another rising edge.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cfg_q.mode && (cfg_q.len == '0)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          armed_d = 1'b0;
        end else begin
          // High phase with enable gone: keep counting until the fall.
          if (!enable) state_d = S_STOP;
          if (toggle) begin
            cnt_d = '0;
            clk_d = ~clk_q;
            apply = pend_q;
            if (!clk_q) begin
              tick_d = 1'b1;
            end else if (!enable) begin
              state_d = S_IDLE;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
              if (cfg_q.mode && (bcnt_d == cfg_q.len)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                armed_d = 1'b0;
              end
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_STOP: begin
        // Only the falling toggle can occur here.
        if (toggle) begin
          cnt_d   = '0;
          clk_d   = 1'b0;
          apply   = pend_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Apply the old pending value first; a load on the same edge then
    // becomes the new pending value.
    if (apply) begin
      half_d = pval_q;
      ack_d  = 1'b1;
      pend_d = 1'b0;
    end
    if (load) begin
      pend_d = 1'b1;
      pval_d = half_in_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      half_q  <= RST_HALF;
      pval_q  <= RST_HALF;
      pend_q  <= 1'b0;
      bcnt_q  <= '0;
      cfg_q   <= '0;
      armed_q <= 1'b1;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      bcnt_q  <= bcnt_d;
      cfg_q   <= cfg_d;
      armed_q <= armed_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign clk_out  = clk_q;
  assign tick     = tick_q;
  assign load_ack = ack_q;
  assign done     = done_q;
  assign cur_half = half_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_clk_div_sched.sv
module tb_clk_div_sched;
  localparam int CW = 8;
  localparam int BW = 16;
  localparam int DH = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable, burst_mode, load;
  logic [BW-1:0] burst_len;
  logic [CW-1:0] half_in;
  logic          load_ack, clk_out, tick, busy, done;
  logic [CW-1:0] cur_half;

  always #5 clk = ~clk;

  clk_div_sched #(.CW(CW), .DEFAULT_HALF(DH), .BW(BW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .burst_mode(burst_mode),
    .burst_len(burst_len), .half_in(half_in), .load(load),
    .load_ack(load_ack), .cur_half(cur_half), .clk_out(clk_out),
    .tick(tick), .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the absolute edge number of the next toggle
  // instead of a phase counter.
  int cyc = 0;
  bit m_run, m_stop, m_lvl, m_pend, m_armed, m_bmode, m_tick, m_ack, m_done;
  int m_next, m_half, m_pval, m_blen, m_falls;

  task automatic model_reset();
    m_run = 0; m_stop = 0; m_lvl = 0; m_pend = 0; m_armed = 1;
    m_tick = 0; m_ack = 0; m_done = 0; m_bmode = 0; m_blen = 0; m_falls = 0;
    m_half = (DH == 0) ? 1 : DH;
    m_pval = m_half; m_next = 0;
  endtask

  task automatic model_edge();
    cyc++;
    m_tick = 0; m_ack = 0; m_done = 0;
    if (!m_run) begin
      if (m_pend) begin
        m_half = m_pval; m_ack = 1; m_pend = 0;
      end else if (enable && m_armed && !load) begin
        m_run = 1; m_stop = 0; m_next = cyc + m_half;
        m_bmode = burst_mode; m_blen = burst_len; m_falls = 0;
      end
      if (!enable) m_armed = 1;
    end else if (!m_stop && !enable && !m_lvl) begin
      m_run = 0;
    end else if (!m_stop && m_bmode && m_blen == 0) begin
      m_run = 0; m_done = 1; m_armed = 0;
    end else begin
      if (!enable) m_stop = 1;
      if (cyc == m_next) begin
        m_lvl = !m_lvl;
        if (m_pend) begin m_half = m_pval; m_ack = 1; m_pend = 0; end
        m_next = cyc + m_half;
        if (m_lvl) m_tick = 1;
        else if (m_stop) begin m_run = 0; m_stop = 0; end
        else begin
          m_falls++;
          if (m_bmode && m_falls == m_blen) begin m_run = 0; m_done = 1; m_armed = 0; end
        end
      end
    end
    if (load) begin
      m_pend = 1;
      m_pval = (half_in == 0) ? 1 : int'(half_in);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    chk("model_clk_out", clk_out, m_lvl);
    chk("model_tick", tick, m_tick);
    chk("model_busy", busy, m_run);
    chk("model_done", done, m_done);
    chk("model_load_ack", load_ack, m_ack);
    chk("model_cur_half", cur_half, m_half);
  endtask

  task automatic do_reset();
    reset = 1; enable = 0; load = 0; burst_mode = 0; burst_len = '0; half_in = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  // which: 0 = tick, 1 = load_ack, 2 = busy low. n = steps taken, -1 on timeout.
  task automatic wait_sig(input int which, output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if ((which == 0 && tick) || (which == 1 && load_ack) || (which == 2 && !busy)) begin
        n = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic          en, ld;
    logic [CW-1:0] hin;
    logic [BW-1:0] bl;
    logic          e_clk, e_tick, e_busy, e_done, e_ack;
    logic [CW-1:0] e_half;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic ld, input logic [CW-1:0] hin,
                              input logic [BW-1:0] bl, input logic c, input logic t,
                              input logic b, input logic d, input logic a,
                              input logic [CW-1:0] h);
    vec_t v;
    v.en = en; v.ld = ld; v.hin = hin; v.bl = bl;
    v.e_clk = c; v.e_tick = t; v.e_busy = b; v.e_done = d; v.e_ack = a; v.e_half = h;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[$];
    int   rises[$];
    int   n, n2, hi, acks;

    // Burst of 4 at half 2, hold-enable no-restart, then burst_len 0.
    vt.push_back(mk(0, 1, 2, 4, 0, 0, 0, 0, 0, 6));
    vt.push_back(mk(1, 0, 0, 4, 0, 0, 0, 0, 1, 2));
    vt.push_back(mk(1, 0, 0, 4, 0, 0, 1, 0, 0, 2));
    vt.push_back(mk(1, 0, 0, 4, 0, 0, 1, 0, 0, 2));
    for (int p = 0; p < 4; p++) begin
      vt.push_back(mk(1, 0, 0, 4, 1, 1, 1, 0, 0, 2));
      vt.push_back(mk(1, 0, 0, 4, 1, 0, 1, 0, 0, 2));
      if (p < 3) begin
        vt.push_back(mk(1, 0, 0, 4, 0, 0, 1, 0, 0, 2));
        vt.push_back(mk(1, 0, 0, 4, 0, 0, 1, 0, 0, 2));
      end
    end
    vt.push_back(mk(1, 0, 0, 4, 0, 0, 0, 1, 0, 2));
    vt.push_back(mk(1, 0, 0, 4, 0, 0, 0, 0, 0, 2));
    vt.push_back(mk(1, 0, 0, 4, 0, 0, 0, 0, 0, 2));
    vt.push_back(mk(0, 0, 0, 4, 0, 0, 0, 0, 0, 2));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 2));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2));

    // Reset state.
    do_reset();
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_load_ack", load_ack, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur_half", cur_half, DH);

    // Free-run at default half: first rise 6 edges after start, period 12.
    enable = 1;
    step();
    chk("fr_busy_at_start", busy, 1);
    for (int i = 1; i <= 30; i++) begin
      step();
      if (tick) rises.push_back(i);
    end
    chk("fr_rise_count", rises.size(), 3);
    if (rises.size() >= 2) begin
      chk("fr_first_rise", rises[0], 6);
      chk("fr_period", rises[1] - rises[0], 12);
    end

    // Reload to 3 mid high phase: high phase stays 6, then period 6.
    step(); step();
    load = 1; half_in = 3;
    step();
    load = 0;
    wait_sig(1, n);
    chk("reload_ack_delay", n, 3);
    chk("reload_cur_half", cur_half, 3);
    chk("reload_clk_low_at_ack", clk_out, 0);
    wait_sig(0, n);
    chk("reload_low_phase", n, 3);
    wait_sig(0, n);
    chk("reload_new_period", n, 6);

    // Half 5, drop enable one cycle after a rise: full 5-cycle high phase.
    load = 1; half_in = 5;
    step();
    load = 0;
    wait_sig(1, n);
    chk("h5_ack_seen", n > 0, 1);
    wait_sig(0, n);
    chk("h5_tick_seen", n > 0, 1);
    hi = 1;
    step();
    hi++;
    enable = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!clk_out) break;
      hi++;
    end
    chk("stop_high_cycles", hi, 5);
    chk("stop_busy", busy, 0);
    chk("stop_no_done", done, 0);

    // Two loads before a toggle: one ack, last value wins.
    enable = 1;
    step();
    load = 1; half_in = 7;
    step();
    half_in = 9;
    step();
    load = 0;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (load_ack) acks++;
    end
    chk("dbl_load_acks", acks, 1);
    chk("dbl_load_half", cur_half, 9);
    enable = 0;
    wait_sig(2, n);
    chk("dbl_stop_timeout", n > 0, 1);

    // Load 0 clamps to 1: period 2.
    load = 1; half_in = 0;
    step();
    load = 0;
    wait_sig(1, n);
    chk("zero_ack_delay", n, 1);
    chk("zero_clamped", cur_half, 1);
    enable = 1;
    wait_sig(0, n);
    wait_sig(0, n2);
    chk("zero_period", n2, 2);
    enable = 0;
    wait_sig(2, n);
    chk("zero_stop_timeout", n > 0, 1);

    // Vector table.
    do_reset();
    burst_mode = 1;
    foreach (vt[i]) begin
      enable = vt[i].en; load = vt[i].ld; half_in = vt[i].hin; burst_len = vt[i].bl;
      step();
      chk($sformatf("vec%0d_clk_out", i), clk_out, vt[i].e_clk);
      chk($sformatf("vec%0d_tick", i), tick, vt[i].e_tick);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("vec%0d_done", i), done, vt[i].e_done);
      chk($sformatf("vec%0d_load_ack", i), load_ack, vt[i].e_ack);
      chk($sformatf("vec%0d_cur_half", i), cur_half, vt[i].e_half);
    end

    // Async reset in the middle of a high phase.
    do_reset();
    enable = 1;
    wait_sig(0, n);
    chk("arst_tick_seen", n, 7);
    step(); step();
    #3;
    reset = 1;
    #1;
    chk("arst_clk_out", clk_out, 0);
    chk("arst_cur_half", cur_half, DH);
    chk("arst_busy", busy, 0);
    model_reset();
    enable = 0;
    @(posedge clk);
    #1;
    reset = 0;

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      load = ($urandom_range(0, 9) == 0);
      half_in = CW'($urandom_range(0, 7));
      burst_mode = 1'($urandom_range(0, 1));
      burst_len = BW'($urandom_range(0, 5));
      if ($urandom_range(0, 599) == 0) do_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Programmable test-clock scheduler. Derives a divided clock `clk_out` from the system clock `clk`.
- The output half-period is reloadable at run time. A new half-period takes effect only at a toggle boundary, so `clk_out` never has a truncated or glitched phase.
- Supports free-run and burst (N-period) modes, plus a graceful stop.
- Sits between testbench/control logic and any block that needs a derived clock or clock-enable, e.g. a frequency-doubling check via half-period reload.

Parameters:
- CW, 8, width of the half-period counter and half-period registers.
- DEFAULT_HALF, 6, half-period (in clk cycles) after reset. Output period = 2*DEFAULT_HALF.
- BW, 16, width of the burst length counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  run request (level).
- burst_mode  input  1  sampled at start: 1 = burst, 0 = free-run.
- burst_len  input  BW  number of full clk_out periods in burst mode; sampled at start.
- half_in  input  CW  new half-period value.
- load  input  1  one-cycle strobe: capture half_in as pending half-period.
- load_ack  output  1  one-cycle pulse on the cycle cur_half takes the pending value.
- cur_half  output  CW  half-period currently in effect.
- clk_out  output  1  divided clock (registered).
- tick  output  1  one-cycle pulse, high on the same cycle clk_out first reads 1 after a rising toggle.
- busy  output  1  high in RUN or STOP_PEND.
- done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (async, immediate):
  - clk_out=0, tick=0, load_ack=0, done=0, busy=0.
  - cur_half=DEFAULT_HALF, pending flag=0, cnt=0, burst counter=0, state=IDLE, armed=1.
- Half-period value 0 is clamped to 1, both at load and for DEFAULT_HALF.
- States: IDLE, RUN, STOP_PEND.
- IDLE:
  - clk_out=0, cnt=0.
  - If enable=1 and armed=1: go to RUN; latch burst_mode and burst_len; clear burst counter.
  - If enable=0: set armed=1.
  - Pending load in IDLE: applied on the next edge (cur_half updated, load_ack pulse).
- RUN, per edge:
  - If cnt==cur_half-1: toggle clk_out, set cnt=0. Otherwise cnt=cnt+1.
  - The first rising toggle occurs cur_half edges after the start edge.
  - Pending half-period is applied only on a toggle edge; load_ack pulses in the same cycle that cur_half changes.
  - On a 0->1 toggle: tick=1 for one cycle, aligned with clk_out high.
- Load rules:
  - load while a value is already pending overwrites it; only one load_ack is issued.
  - If load coincides with the apply edge, the old pending value is applied and the new one stays pending.
- Stop (enable=0 while in RUN, free-run mode):
  - If clk_out=0: go to IDLE on the next edge.
  - If clk_out=1: go to STOP_PEND, finish the high phase (normal count), toggle to 0, then go to IDLE.
  - No shortened high pulse is ever produced.
- Burst mode:
  - Burst counter increments on each 1->0 toggle.
  - When it reaches burst_len: clk_out goes to 0, state goes to IDLE, done=1 for one cycle, armed=0.
  - A new start requires enable low for at least one cycle.
  - burst_len=0: done pulses on the edge after start, no clk_out pulses, armed=0.
  - enable=0 during a burst behaves as a stop; no done pulse.
- busy: 1 exactly while state is RUN or STOP_PEND.
- Simultaneous enable rise and load in IDLE: the load is applied first, and the run uses the new half-period.
- Counter never exceeds cur_half-1.
- If cur_half decreases while cnt is above the new limit: cannot occur, because cnt=0 at every apply edge.

Test Plan:
- Reset, enable=1, free-run, default half 6 -> clk_out rises 6 edges after start; period 12 clk; tick every 12 cycles; busy=1.
- While running at half 6, load half_in=3 mid high phase -> current high phase stays 6 cycles; load_ack and cur_half=3 at that toggle; thereafter period 6 (doubled frequency).
- burst_mode=1, burst_len=4, half=2 -> exactly 4 clk_out pulses of 2 high/2 low; done pulse on the edge of the 4th falling toggle; busy drops; holding enable=1 does not restart; enable low then high restarts.
- enable dropped 1 cycle after a rising toggle at half 5 -> clk_out stays high for the full 5 cycles, then 0; state IDLE; no done.
- load half_in=0 -> cur_half=1; period 2. Two loads (7 then 9) before a toggle -> single load_ack, cur_half=9.
- reset asserted asynchronously mid high phase -> clk_out=0 immediately, before the next clk edge; cur_half=6; IDLE.
